// File: rtl/program_sequencer_if.sv
// Bus between the program sequencer and its memories/ALU.
interface program_sequencer_if;
  logic        start;
  logic [11:0] inst_read;
  logic        exec_done;
  logic [4:0]  inst_address;
  logic        load_instrs;
  logic [2:0]  address_select;
  logic        nEnable;
  logic        ReadWrite;
  logic [2:0]  opcode;
  logic        cap_a;
  logic        cap_b;
  logic        alu_start;
  logic        alu_drive;
  logic        busy;
  logic        done;

  modport master (
    input  start, inst_read, exec_done,
    output inst_address, load_instrs, address_select, nEnable, ReadWrite,
           opcode, cap_a, cap_b, alu_start, alu_drive, busy, done
  );

  modport slave (
    output start, inst_read, exec_done,
    input  inst_address, load_instrs, address_select, nEnable, ReadWrite,
           opcode, cap_a, cap_b, alu_start, alu_drive, busy, done
  );
endinterface

// File: rtl/program_sequencer.sv
// Fetches packed instructions, reads two operands, launches the ALU and writes back.
// Outputs are decoded from the state register or come straight from flops.
module program_sequencer #(
  parameter logic [2:0] PROG_ADDR = 3'd2,
  parameter logic [4:0] LAST_PC   = 5'd20
) (
  input  logic                 clk,
  input  logic                 Reset,
  program_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t      state, nxt;
  logic [4:0]  pc;
  logic [11:0] ir;
  logic [2:0]  opcode_q;
  logic        alu_start_q;

  always_ff @(posedge clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) nxt = S_LOAD;
      S_LOAD:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = (bus.inst_read[11:9] == 3'b111) ? S_DONE : S_READ_A;
      S_READ_A: nxt = S_READ_B;
      S_READ_B: nxt = S_EXEC;
      S_EXEC:   if (bus.exec_done) nxt = S_WRITE;
      S_WRITE:  nxt = (pc == LAST_PC) ? S_DONE : S_FETCH;
      default:  nxt = S_IDLE;
    endcase
  end

  // alu_start is a flop set on the READ_B->EXEC edge, so it only covers the first EXEC cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pc          <= '0;
      ir          <= '0;
      opcode_q    <= '0;
      alu_start_q <= 1'b0;
    end else begin
      alu_start_q <= (state == S_READ_B);
      case (state)
        S_LOAD:   pc <= '0;
        S_DECODE: begin
          ir       <= bus.inst_read;
          opcode_q <= bus.inst_read[11:9];
        end
        S_WRITE:  if (pc != LAST_PC) pc <= pc + 5'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    bus.inst_address   = pc;
    bus.opcode         = opcode_q;
    bus.alu_start      = alu_start_q;
    bus.address_select = 3'd0;
    bus.nEnable        = 1'b1;
    bus.ReadWrite      = 1'b1;
    bus.load_instrs    = 1'b0;
    bus.cap_a          = 1'b0;
    bus.cap_b          = 1'b0;
    bus.alu_drive      = 1'b0;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    case (state)
      S_LOAD: begin
        bus.address_select = PROG_ADDR;
        bus.nEnable        = 1'b0;
        bus.load_instrs    = 1'b1;
        bus.busy           = 1'b1;
      end
      S_FETCH, S_DECODE, S_EXEC: bus.busy = 1'b1;
      S_READ_A: begin
        bus.address_select = ir[8:6];
        bus.nEnable        = 1'b0;
        bus.cap_a          = 1'b1;
        bus.busy           = 1'b1;
      end
      S_READ_B: begin
        bus.address_select = ir[5:3];
        bus.nEnable        = 1'b0;
        bus.cap_b          = 1'b1;
        bus.busy           = 1'b1;
      end
      S_WRITE: begin
        bus.address_select = ir[2:0];
        bus.nEnable        = 1'b0;
        bus.ReadWrite      = 1'b0;
        bus.alu_drive      = 1'b1;
        bus.busy           = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Drives random programs and ALU latencies; checks the memory transaction stream and timing.
module tb_program_sequencer;
  logic clk;
  logic Reset;
  program_sequencer_if ifc ();

  program_sequencer #(.PROG_ADDR(3'd2), .LAST_PC(5'd20)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [11:0] prog [0:31];
  int          lat  [0:31];
  assign ifc.inst_read = prog[ifc.inst_address];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_iaddr"}, 32'(ifc.inst_address), 32'd0);
    check({tag, "_asel"},  32'(ifc.address_select), 32'd0);
    check({tag, "_nen"},   32'(ifc.nEnable), 32'd1);
    check({tag, "_rw"},    32'(ifc.ReadWrite), 32'd1);
    check({tag, "_op"},    32'(ifc.opcode), 32'd0);
    check({tag, "_strb"},  32'({ifc.load_instrs, ifc.cap_a, ifc.cap_b, ifc.alu_start, ifc.alu_drive}), 32'd0);
    check({tag, "_stat"},  32'({ifc.busy, ifc.done}), 32'd0);
  endtask

  // Random non-HALT program; optional HALT at position halt_at (negative = none).
  task automatic fill(input int halt_at, input int maxlat);
    for (int i = 0; i < 32; i++) begin
      prog[i] = {3'($urandom_range(0, 6)), 9'($urandom)};
      lat[i]  = $urandom_range(0, maxlat);
    end
    if (halt_at >= 0) prog[halt_at] = {3'b111, 9'($urandom)};
  endtask

  // Model: LOAD, then per instruction read A / read B / write dest until HALT or index 20.
  // Cycle budget: LOAD 1, instruction 6+latency, HALT fetch/decode 2, then DONE.
  task automatic execute(input string tag, input bit noise);
    logic [7:0] q[$];
    int         wpc[$];
    int         ops[$];
    int         tcyc, last, k, idx, wcnt, n_alu;
    bit         pend, finished;
    logic [7:0] obs;
    q.delete(); wpc.delete(); ops.delete();
    q.push_back({5'b10001, 3'd2});
    tcyc = 1; last = 0;
    for (int i = 0; i <= 20; i++) begin
      last = i;
      if (prog[i][11:9] == 3'b111) begin
        tcyc += 2;
        break;
      end
      q.push_back({5'b01001, prog[i][8:6]});
      q.push_back({5'b00101, prog[i][5:3]});
      q.push_back({5'b00010, prog[i][2:0]});
      wpc.push_back(i);
      ops.push_back(int'(prog[i][11:9]));
      tcyc += 6 + lat[i];
    end
    tcyc += 1;
    n_alu = ops.size();

    ifc.start = 1'b1;
    k = 0; idx = 0; wcnt = 0; pend = 0; finished = 0;
    while (!finished && k < 1000) begin
      @(negedge clk);
      k++;
      ifc.start = 1'b0;
      ifc.exec_done = 1'b0;
      if (ifc.done) begin
        finished = 1;
        check({tag, "_cycles"}, 32'(k), 32'(tcyc));
        check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        check({tag, "_final_pc"}, 32'(ifc.inst_address), 32'(last));
        check({tag, "_txn_left"}, 32'(q.size()), 32'd0);
        check({tag, "_alu_cnt"}, 32'(idx), 32'(n_alu));
        check({tag, "_done_bus"}, 32'({ifc.nEnable, ifc.ReadWrite}), 32'h3);
      end else begin
        if (!ifc.nEnable || ifc.load_instrs || ifc.cap_a || ifc.cap_b || ifc.alu_drive) begin
          obs = {ifc.load_instrs, ifc.cap_a, ifc.cap_b, ifc.alu_drive, ifc.ReadWrite, ifc.address_select};
          if (q.size() == 0) check({tag, "_extra_txn"}, 32'(obs), 32'h100);
          else               check({tag, "_txn"}, 32'(obs), 32'(q.pop_front()));
          if (ifc.alu_drive && wpc.size() != 0)
            check({tag, "_wr_pc"}, 32'(ifc.inst_address), 32'(wpc.pop_front()));
        end
        if (ifc.alu_start) begin
          if (ops.size() == 0) check({tag, "_extra_alu"}, 32'(ifc.opcode), 32'h100);
          else                 check({tag, "_opcode"}, 32'(ifc.opcode), 32'(ops.pop_front()));
          wcnt = lat[idx];
          idx++;
          pend = 1;
        end
        if (pend) begin
          if (wcnt == 0) begin
            ifc.exec_done = 1'b1;
            pend = 0;
          end else wcnt--;
        end else if (noise) ifc.exec_done = ($urandom_range(0, 2) == 0);
        if (noise && ifc.busy) ifc.start = ($urandom_range(0, 2) == 0);
      end
    end
    check({tag, "_finished"}, 32'(finished), 32'd1);
  endtask

  initial begin
    bit seen;
    Reset = 1'b1;
    ifc.start = 1'b0;
    ifc.exec_done = 1'b0;
    fill(-1, 0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    Reset = 1'b0;
    @(negedge clk);
    check_reset("idle");

    fill(1, 0);
    prog[0] = 12'h0C5;
    lat[0]  = 3;
    execute("one_instr", 1'b0);

    fill(0, 0);
    execute("halt_first", 1'b0);

    fill(-1, 0);
    execute("full_21", 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill((r % 2 == 0) ? -1 : int'($urandom_range(0, 22)), 4);
      execute($sformatf("rand%0d", r), 1'b1);
    end

    fill(-1, 0);
    lat[0] = 10;
    ifc.start = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      seen = ifc.alu_start;
    end
    check("exec_reached", 32'(seen), 32'd1);
    ifc.exec_done = 1'b1;
    Reset = 1'b1;
    @(negedge clk);
    check_reset("mid_exec_rst");
    Reset = 1'b0;
    ifc.exec_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({ifc.nEnable, ifc.alu_drive, ifc.busy}), 32'h4);
    end

    fill(5, 2);
    execute("after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PROG_ADDR, default 3'd2, RAM address holding the packed program word.
REQ-002 Parameter LAST_PC, default 5'd20, highest instruction index executed before forced completion.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start  input  1  run request; sampled only in IDLE and DONE.
REQ-006 inst_read  input  12  instruction from instruction memory at inst_address.
REQ-007 exec_done  input  1  matrix ALU completion pulse.
REQ-008 inst_address  output  5  program counter driven to instruction memory.
REQ-009 load_instrs  output  1  instruction-memory load strobe.
REQ-010 address_select  output  3  RAM/result-register address.
REQ-011 nEnable  output  1  active-low memory enable.
REQ-012 ReadWrite  output  1  1 = read, 0 = write.
REQ-013 opcode  output  3  registered opcode to ALU.
REQ-014 cap_a, cap_b  output  1 each  ALU operand-capture strobes (latch dataBus).
REQ-015 alu_start  output  1  one-cycle ALU launch pulse.
REQ-016 alu_drive  output  1  ALU result drives dataBus.
REQ-017 busy, done  output  1 each  status flags.

Function
REQ-018 Instruction format: [11:9] opcode, [8:6] srcA, [5:3] srcB, [2:0] dest; opcode 3'b111 = HALT, all others passed to ALU unchanged.
REQ-019 States: IDLE, LOAD, FETCH, DECODE, READ_A, READ_B, EXEC, WRITE, DONE; one state per cycle except EXEC.
REQ-020 IDLE: nEnable=1, ReadWrite=1, all strobes 0, busy=0; start=1 -> LOAD.
REQ-021 LOAD (1 cycle): address_select=PROG_ADDR, ReadWrite=1, nEnable=0, load_instrs=1, pc<=0; -> FETCH.
REQ-022 FETCH (1 cycle): inst_address=pc, nEnable=1; -> DECODE.
REQ-023 DECODE: ir<=inst_read, opcode<=inst_read[11:9]; HALT -> DONE, else -> READ_A.
REQ-024 READ_A: address_select=srcA, nEnable=0, ReadWrite=1, cap_a=1; -> READ_B.
REQ-025 READ_B: address_select=srcB, nEnable=0, ReadWrite=1, cap_b=1; -> EXEC.
REQ-026 EXEC: alu_start=1 on first EXEC cycle only, nEnable=1; stays until exec_done=1, then -> WRITE.
REQ-027 exec_done arriving in the same cycle as alu_start is accepted (EXEC lasts 1 cycle).
REQ-028 WRITE (1 cycle): address_select=dest, ReadWrite=0, nEnable=0, alu_drive=1; if pc==LAST_PC -> DONE, else pc<=pc+1 and -> FETCH.
REQ-029 pc is 5 bits and never wraps; LAST_PC bounds it.
REQ-030 alu_drive=1 only in WRITE; cap_a, cap_b, load_instrs never asserted simultaneously with ReadWrite=0.
REQ-031 busy=1 in LOAD through WRITE; done=1 only in DONE.
REQ-032 DONE: holds bus idle; start=1 -> LOAD (rerun, program reloaded).
REQ-033 start while busy is ignored; exec_done outside EXEC is ignored.
REQ-034 Outputs are registered or decoded from state register only; no combinational path from inputs to outputs.

Reset
REQ-035 Reset=1 on any edge, including mid-EXEC or mid-WRITE, -> IDLE next cycle, overriding start and exec_done.
REQ-036 Reset values: inst_address=0, address_select=0, nEnable=1, ReadWrite=1, opcode=0, load_instrs=0, cap_a=0, cap_b=0, alu_start=0, alu_drive=0, busy=0, done=0, pc=0, ir=0.

Verification
REQ-037 Reset then start pulse -> exactly one load_instrs cycle with address_select=2, nEnable=0, ReadWrite=1; FETCH next with inst_address=0.
REQ-038 inst_read=12'h0C5 (opcode 0, srcA 3, srcB 0, dest 5), exec_done 3 cycles after alu_start -> cap_a at address 3, cap_b at address 0, write at address 5 with ReadWrite=0, then inst_address=1.
REQ-039 inst_read=12'hE00 at pc=0 -> DONE after DECODE, no cap/alu strobes, done=1, busy=0.
REQ-040 Non-HALT program of 21 instructions, exec_done same cycle as alu_start -> 21 WRITE cycles, pc stops at 20, done=1, no pc wrap.
REQ-041 Reset asserted during EXEC with exec_done pending -> IDLE next cycle, all outputs at reset values, no WRITE issued.
REQ-042 start pulsed during READ_B and exec_done pulsed during FETCH -> both ignored; sequence unchanged.
